// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one READ/WRITE request at a time against a word array
// and returns a single registered response a fixed LATENCY cycles after acceptance.
module dmem_responder #(
  parameter int N_BITS      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_mtype,
  input  logic [N_BITS-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic [N_BITS-1:0] req_data,
  output logic              resp_vld,
  output logic              resp_mtype,
  output logic [N_BITS-1:0] resp_data,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int LANES = N_BITS / 8;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;
  localparam logic [1:0] LEN_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               accept;
  logic               load_resp;

  logic [N_BITS-1:0]  word_idx_full;
  logic [IDX_W-1:0]   req_idx;
  logic [1:0]         req_lane;
  logic               range_err;
  logic               req_err;
  logic [LANES-1:0]   wr_be;
  logic [N_BITS-1:0]  wr_word;
  logic [N_BITS-1:0]  rd_word_live;

  logic               fin_mtype;
  logic               fin_err;
  logic [N_BITS-1:0]  fin_data;

  logic [N_BITS-1:0]  mem [DEPTH_WORDS];

  // Shift the addressed word down to lane 0 and keep only the requested width.
  function automatic logic [N_BITS-1:0] fmt_read(input logic [N_BITS-1:0] word,
                                                 input logic [1:0]        lane,
                                                 input logic [1:0]        len);
    logic [N_BITS-1:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (len)
      LEN_BYTE: fmt_read = {{(N_BITS-8){1'b0}}, shifted[7:0]};
      LEN_HALF: fmt_read = {{(N_BITS-16){1'b0}}, shifted[15:0]};
      default:  fmt_read = shifted;
    endcase
  endfunction

  assign req_rdy   = (state_q == S_IDLE) && !rst;
  assign accept    = req_vld && req_rdy;
  assign resp_vld  = (state_q == S_RESP);

  // Request decode. The full word index is compared so high address bits never alias.
  assign word_idx_full = {2'b00, req_addr[N_BITS-1:2]};
  assign req_idx       = req_addr[IDX_W+1:2];
  assign req_lane      = req_addr[1:0];
  assign range_err     = (word_idx_full >= N_BITS'(DEPTH_WORDS));
  assign req_err       = (req_len == LEN_RSVD)
                       | ((req_len == LEN_HALF) & req_addr[0])
                       | ((req_len == LEN_WORD) & (req_addr[1:0] != 2'b00))
                       | range_err;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_be = '0;
    case (req_len)
      LEN_BYTE: wr_be = LANES'(4'b0001) << req_lane;
      LEN_HALF: wr_be = LANES'(4'b0011) << req_lane;
      LEN_WORD: wr_be = '1;
      default:  wr_be = '0;
    endcase
  end

  assign wr_word      = req_data << {req_lane, 3'b000};
  assign rd_word_live = mem[req_idx];

  // NOTE: the array has no reset; clearing it would cost a write port per word and
  // software never relies on its initial contents.
  always_ff @(posedge clk) begin
    if (accept && req_mtype && !req_err) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_be[b]) begin
          mem[req_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // With a single-cycle latency the response is built straight from the accepted
  // request; otherwise the request fields and read word are held until RESP.
  generate
    if (LATENCY == 1) begin : g_direct
      assign fin_mtype = req_mtype;
      assign fin_err   = req_err;
      assign fin_data  = fmt_read(rd_word_live, req_lane, req_len);
    end else begin : g_held
      logic              mtype_q;
      logic              err_q;
      logic [1:0]        len_q;
      logic [1:0]        lane_q;
      logic [N_BITS-1:0] word_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          mtype_q <= 1'b0;
          err_q   <= 1'b0;
          len_q   <= '0;
          lane_q  <= '0;
          word_q  <= '0;
        end else if (accept) begin
          mtype_q <= req_mtype;
          err_q   <= req_err;
          len_q   <= req_len;
          lane_q  <= req_lane;
          word_q  <= rd_word_live;
        end
      end

      assign fin_mtype = mtype_q;
      assign fin_err   = err_q;
      assign fin_data  = fmt_read(word_q, lane_q, len_q);
    end
  endgenerate

  // Response registers change only on entry to RESP and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_mtype <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else if (load_resp) begin
      resp_mtype <= fin_mtype;
      resp_err   <= fin_err;
      resp_data  <= (fin_err || fin_mtype) ? '0 : fin_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, multi-cycle corner
// sequences, and random traffic against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int DEPTH    = 1024;
  localparam int DEPTH_L1 = 16;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_vld, req_rdy, req_mtype;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_len;
  logic        resp_vld, resp_mtype, resp_err;
  logic [31:0] resp_data;

  logic        l1_req_vld, l1_req_rdy, l1_req_mtype;
  logic [31:0] l1_req_addr, l1_req_data;
  logic [1:0]  l1_req_len;
  logic        l1_resp_vld, l1_resp_mtype, l1_resp_err;
  logic [31:0] l1_resp_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.N_BITS(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_mtype(req_mtype),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .resp_vld(resp_vld), .resp_mtype(resp_mtype), .resp_data(resp_data), .resp_err(resp_err)
  );

  dmem_responder #(.N_BITS(32), .DEPTH_WORDS(DEPTH_L1), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_vld(l1_req_vld), .req_rdy(l1_req_rdy), .req_mtype(l1_req_mtype),
    .req_addr(l1_req_addr), .req_len(l1_req_len), .req_data(l1_req_data),
    .resp_vld(l1_resp_vld), .resp_mtype(l1_resp_mtype), .resp_data(l1_resp_data),
    .resp_err(l1_resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a flat byte array, little-endian within each word.
  logic [7:0] bmem [4*DEPTH];

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] l);
    return (l == 2'd3) || (l == 2'd1 && (a % 2) != 0) || (l == 2'd2 && (a % 4) != 0)
           || ((a / 4) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] l);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < (1 << l); k++) r = r | (32'(bmem[a + k]) << (8 * k));
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    for (int k = 0; k < (1 << l); k++) bmem[a + k] = d[8*k +: 8];
  endtask

  // One complete transaction on the LATENCY=2 instance with all response checks.
  task automatic xact(input string tag, input logic mt, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d,
                      input logic [31:0] exp_data, input logic exp_err);
    int n;
    int lat;
    @(negedge clk);
    req_vld = 1'b1; req_mtype = mt; req_addr = a; req_len = l; req_data = d;
    n = 0;
    while (!req_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = -1;
    if (req_rdy) begin
      @(negedge clk);
      req_vld = 1'b0;
      lat = 1;
      while (!resp_vld && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      if (!resp_vld) lat = -1;
    end
    req_vld = 1'b0;
    check({tag, " latency"}, lat, 2);
    check({tag, " mtype"}, resp_mtype, mt);
    check({tag, " err"}, resp_err, exp_err);
    check({tag, " data"}, resp_data, exp_data);
    @(negedge clk);
    check({tag, " single pulse"}, resp_vld, 1'b0);
    check({tag, " data hold"}, resp_data, exp_data);
  endtask

  typedef struct {
    logic        mt;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  function automatic vec_t mkv(input logic mt, input logic [31:0] a, input logic [1:0] l,
                               input logic [31:0] d, input logic [31:0] e, input logic er);
    vec_t v;
    v.mt = mt; v.addr = a; v.len = l; v.data = d; v.exp = e; v.err = er;
    return v;
  endfunction

  vec_t        vecs[$];
  logic [31:0] t4_addr [3] = '{32'h10, 32'h13, 32'h12};
  logic [1:0]  t4_len  [3] = '{2'd2, 2'd0, 2'd1};
  logic [31:0] t4_exp  [3] = '{32'hABADBEEF, 32'h000000AB, 32'h0000ABAD};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc[$];
    int          rsp[$];
    logic [31:0] rdat[$];
    logic        rdy_hist [20];
    int          k;
    logic        took;

    rst = 1'b1;
    req_vld = 1'b0; req_mtype = 1'b0; req_addr = '0; req_len = '0; req_data = '0;
    l1_req_vld = 1'b0; l1_req_mtype = 1'b0; l1_req_addr = '0; l1_req_len = '0; l1_req_data = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset rdy low", req_rdy, 1'b0);
    check("reset resp_vld", resp_vld, 1'b0);
    check("reset resp_data", resp_data, 32'h0);
    check("reset resp_err", resp_err, 1'b0);
    check("reset resp_mtype", resp_mtype, 1'b0);
    rst = 1'b0;
    #1;
    check("rdy after reset", req_rdy, 1'b1);

    // Directed vector table.
    vecs.push_back(mkv(1'b1, 32'h10,   2'd2, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mkv(1'b0, 32'h10,   2'd2, 32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mkv(1'b1, 32'h13,   2'd0, 32'h000000AB, 32'h0,        1'b0));
    vecs.push_back(mkv(1'b0, 32'h10,   2'd2, 32'h0,        32'hABADBEEF, 1'b0));
    vecs.push_back(mkv(1'b0, 32'h13,   2'd0, 32'h0,        32'h000000AB, 1'b0));
    vecs.push_back(mkv(1'b0, 32'h12,   2'd1, 32'h0,        32'h0000ABAD, 1'b0));
    vecs.push_back(mkv(1'b0, 32'h11,   2'd1, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mkv(1'b1, 32'h12,   2'd2, 32'h11111111, 32'h0,        1'b1));
    vecs.push_back(mkv(1'b0, 32'h10,   2'd3, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mkv(1'b0, 32'h10,   2'd2, 32'h0,        32'hABADBEEF, 1'b0));
    vecs.push_back(mkv(1'b0, 32'h1000, 2'd2, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mkv(1'b1, 32'hFFFFFFFC, 2'd2, 32'h22222222, 32'h0,    1'b1));
    vecs.push_back(mkv(1'b1, 32'h14,   2'd2, 32'h01020304, 32'h0,        1'b0));
    vecs.push_back(mkv(1'b1, 32'h16,   2'd1, 32'hFFFFBEEF, 32'h0,        1'b0));
    vecs.push_back(mkv(1'b0, 32'h14,   2'd2, 32'h0,        32'hBEEF0304, 1'b0));
    vecs.push_back(mkv(1'b0, 32'h14,   2'd1, 32'h0,        32'h00000304, 1'b0));
    vecs.push_back(mkv(1'b0, 32'h16,   2'd0, 32'h0,        32'h000000EF, 1'b0));
    vecs.push_back(mkv(1'b0, 32'h17,   2'd0, 32'h0,        32'h000000BE, 1'b0));
    vecs.push_back(mkv(1'b1, 32'hFFF,  2'd0, 32'h00000077, 32'h0,        1'b0));
    vecs.push_back(mkv(1'b0, 32'hFFF,  2'd0, 32'h0,        32'h00000077, 1'b0));

    foreach (vecs[i]) begin
      xact($sformatf("vec%0d", i), vecs[i].mt, vecs[i].addr, vecs[i].len, vecs[i].data,
           vecs[i].exp, vecs[i].err);
      if (vecs[i].mt && !vecs[i].err) model_write(vecs[i].addr, vecs[i].len, vecs[i].data);
    end

    // Held req_vld: three back-to-back reads, one accept every third cycle.
    @(negedge clk);
    k = 0;
    req_mtype = 1'b0; req_addr = t4_addr[0]; req_len = t4_len[0]; req_vld = 1'b1;
    took = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (took) begin
          k++;
          if (k < 3) begin
            req_addr = t4_addr[k]; req_len = t4_len[k];
          end else begin
            req_vld = 1'b0;
          end
        end
      end
      took = 1'b0;
      rdy_hist[cyc] = req_rdy;
      if (resp_vld) begin
        rsp.push_back(cyc);
        rdat.push_back(resp_data);
      end
      if (req_vld && req_rdy) begin
        acc.push_back(cyc);
        took = 1'b1;
      end
    end
    check("b2b accept count", acc.size(), 3);
    check("b2b response count", rsp.size(), 3);
    if (acc.size() == 3 && rsp.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b rdy low +1 after accept%0d", i), rdy_hist[acc[i] + 1], 1'b0);
        check($sformatf("b2b rdy low +2 after accept%0d", i), rdy_hist[acc[i] + 2], 1'b0);
        check($sformatf("b2b resp%0d latency", i), rsp[i] - acc[i], 2);
        check($sformatf("b2b resp%0d data", i), rdat[i], t4_exp[i]);
      end
      check("b2b accept spacing 0-1", acc[1] - acc[0], 3);
      check("b2b accept spacing 1-2", acc[2] - acc[1], 3);
    end

    // Reset pulsed during WAIT: first a READ, then a WRITE whose commit must survive.
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      req_vld = 1'b1; req_mtype = m[0];
      req_addr = (m == 0) ? 32'h10 : 32'h20;
      req_len = 2'd2; req_data = 32'h12345678;
      check($sformatf("rst%0d rdy before accept", m), req_rdy, 1'b1);
      @(negedge clk);
      req_vld = 1'b0;
      check($sformatf("rst%0d rdy low in wait", m), req_rdy, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check($sformatf("rst%0d rdy after rst", m), req_rdy, 1'b1);
      check($sformatf("rst%0d resp_data", m), resp_data, 32'h0);
      check($sformatf("rst%0d resp_err", m), resp_err, 1'b0);
      check($sformatf("rst%0d resp_mtype", m), resp_mtype, 1'b0);
      for (int c = 0; c < 3; c++) begin
        check($sformatf("rst%0d no resp_vld c%0d", m, c), resp_vld, 1'b0);
        @(negedge clk);
      end
    end
    model_write(32'h20, 2'd2, 32'h12345678);
    xact("rst write committed", 1'b0, 32'h20, 2'd2, 32'h0, 32'h12345678, 1'b0);

    // LATENCY=1 instance: response in the cycle right after the handshake.
    @(negedge clk);
    l1_req_vld = 1'b1; l1_req_mtype = 1'b1; l1_req_addr = 32'h0; l1_req_len = 2'd2;
    l1_req_data = 32'hCAFEF00D;
    check("l1 rdy idle", l1_req_rdy, 1'b1);
    @(negedge clk);
    l1_req_vld = 1'b0;
    check("l1 write resp_vld", l1_resp_vld, 1'b1);
    check("l1 write mtype", l1_resp_mtype, 1'b1);
    check("l1 write data", l1_resp_data, 32'h0);
    check("l1 rdy low in resp", l1_req_rdy, 1'b0);
    @(negedge clk);
    check("l1 write single pulse", l1_resp_vld, 1'b0);
    l1_req_vld = 1'b1; l1_req_mtype = 1'b0;
    check("l1 rdy after resp", l1_req_rdy, 1'b1);
    @(negedge clk);
    l1_req_vld = 1'b0;
    check("l1 read resp_vld", l1_resp_vld, 1'b1);
    check("l1 read data", l1_resp_data, 32'hCAFEF00D);
    check("l1 read err", l1_resp_err, 1'b0);
    @(negedge clk);
    check("l1 read single pulse", l1_resp_vld, 1'b0);
    check("l1 read data hold", l1_resp_data, 32'hCAFEF00D);
    l1_req_vld = 1'b1; l1_req_addr = 32'(4 * DEPTH_L1);
    @(negedge clk);
    l1_req_vld = 1'b0;
    check("l1 range resp_vld", l1_resp_vld, 1'b1);
    check("l1 range err", l1_resp_err, 1'b1);
    check("l1 range data", l1_resp_data, 32'h0);

    // Random traffic: prefill bytes 0..127, then mixed requests against the model.
    for (int w = 0; w < 32; w++) begin
      logic [31:0] d;
      d = $urandom;
      xact($sformatf("fill%0d", w), 1'b1, 32'(4 * w), 2'd2, d, 32'h0, 1'b0);
      model_write(32'(4 * w), 2'd2, d);
    end
    for (int r = 0; r < 80; r++) begin
      logic        mt;
      logic [31:0] a;
      logic [1:0]  l;
      logic [31:0] d;
      logic        e;
      logic [31:0] ex;
      mt = 1'($urandom_range(0, 1));
      l  = 2'($urandom_range(0, 3));
      d  = $urandom;
      case ($urandom_range(0, 7))
        0:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 127));
      endcase
      e  = model_err(a, l);
      ex = (mt || e) ? 32'h0 : model_read(a, l);
      xact($sformatf("rnd%0d", r), mt, a, l, d, ex, e);
      if (mt && !e) model_write(a, l, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
